// File: rtl/updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : updown_counter
//  Brief    : Parameterised up/down counter with prescaler, load, wrap or
//             saturate boundary handling, terminal-count pulse and sticky flag.
//  Revision : 1.0 - initial release
// ============================================================================
module updown_counter #(
  parameter int unsigned      WIDTH    = 64,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SAT      = 1'b0,
  parameter int unsigned      PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             match
);

  localparam logic [15:0]      c_ps_last = 16'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [15:0]      pre_q, pre_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic             w_pre_wrap;
  logic             w_step;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_boundary;
  logic [WIDTH-1:0] w_load_clamped;

  // A step fires on the qualified cycle that brings the prescaler back to 0.
  assign w_pre_wrap     = (pre_q == c_ps_last);
  assign w_step         = en & ~load & w_pre_wrap;
  assign w_at_max       = (out_q == MAX_VAL);
  assign w_at_zero      = (out_q == '0);
  assign w_boundary     = w_step & (up ? w_at_max : w_at_zero);
  assign w_load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  always_comb begin
    pre_d = pre_q;
    if (load) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = w_pre_wrap ? 16'd0 : (pre_q + 16'd1);
    end
  end

  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d = w_load_clamped;
    end else if (w_step) begin
      if (up) begin
        if (!w_at_max) begin
          out_d = out_q + c_one;
        end else if (!SAT) begin
          out_d = '0;
        end
      end else begin
        if (!w_at_zero) begin
          out_d = out_q - c_one;
        end else if (!SAT) begin
          out_d = MAX_VAL;
        end
      end
    end
  end

  // Setting wins over a simultaneous clear so no boundary event is lost.
  always_comb begin
    tc_d  = w_boundary;
    ovf_d = w_boundary | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      out_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      out_q <= out_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out   = out_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign match = (out_q == cmp_val);

endmodule
`default_nettype wire

// File: tb/tb_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_updown_counter
//  Brief    : Self-checking bench for updown_counter across wrap, saturate,
//             prescale and 64-bit configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_updown_counter;

  logic        clk = 1'b0;
  logic        rst, en, up, load, clr_ovf;
  logic [3:0]  lv, cmp;
  logic [63:0] lv64, cmp64;
  logic [3:0]  out0, out1, out2;
  logic [63:0] out3;
  logic [3:0]  tc_v, ovf_v, m_v;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SAT(1'b0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .cmp_val(cmp), .clr_ovf(clr_ovf), .out(out0), .tc(tc_v[0]), .ovf(ovf_v[0]),
    .match(m_v[0]));

  updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SAT(1'b1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .cmp_val(cmp), .clr_ovf(clr_ovf), .out(out1), .tc(tc_v[1]), .ovf(ovf_v[1]),
    .match(m_v[1]));

  updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SAT(1'b0), .PRESCALE(3)) u_ps3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .cmp_val(cmp), .clr_ovf(clr_ovf), .out(out2), .tc(tc_v[2]), .ovf(ovf_v[2]),
    .match(m_v[2]));

  updown_counter u_w64 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv64),
    .cmp_val(cmp64), .clr_ovf(clr_ovf), .out(out3), .tc(tc_v[3]), .ovf(ovf_v[3]),
    .match(m_v[3]));

  typedef struct {
    int       sel;
    bit       rst, en, up, ld, clr;
    logic [3:0] lv, cmp, eo;
    bit       etc, eovf, em;
  } vec_t;

  typedef struct {
    int          sel;
    string       name;
    logic [63:0] eo;
    bit          etc, eovf, em;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] get_out(int sel);
    case (sel)
      0:       return {60'd0, out0};
      1:       return {60'd0, out1};
      2:       return {60'd0, out2};
      default: return out3;
    endcase
  endfunction

  function automatic vec_t mk(int sel, bit r, bit e, bit u, bit l, bit c,
                              logic [3:0] lvv, logic [3:0] cmpv, logic [3:0] eo,
                              bit etc, bit eovf, bit em);
    vec_t v;
    v.sel = sel; v.rst = r; v.en = e; v.up = u; v.ld = l; v.clr = c;
    v.lv = lvv; v.cmp = cmpv; v.eo = eo; v.etc = etc; v.eovf = eovf; v.em = em;
    return v;
  endfunction

  task automatic check_exp(exp_t x);
    chk({x.name, ".out"},   get_out(x.sel),          x.eo);
    chk({x.name, ".tc"},    {63'd0, tc_v[x.sel]},    {63'd0, x.etc});
    chk({x.name, ".ovf"},   {63'd0, ovf_v[x.sel]},   {63'd0, x.eovf});
    chk({x.name, ".match"}, {63'd0, m_v[x.sel]},     {63'd0, x.em});
  endtask

  task automatic drive(int sel, string name, bit e, bit u, bit l, bit c,
                       logic [3:0] lvv, logic [3:0] cmpv, logic [63:0] eo,
                       bit etc, bit eovf, bit em);
    exp_t x;
    @(negedge clk);
    en = e; up = u; load = l; clr_ovf = c; lv = lvv; cmp = cmpv;
    x.sel = sel; x.name = name; x.eo = eo; x.etc = etc; x.eovf = eovf; x.em = em;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", name);
    end else begin
      x = sbq.pop_front();
      check_exp(x);
    end
  endtask

  task automatic do_reset(int sel);
    @(negedge clk);
    rst = 1'b1; en = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    #1;
    chk($sformatf("rst%0d.out", sel), get_out(sel), 64'd0);
    chk($sformatf("rst%0d.tc", sel),  {63'd0, tc_v[sel]},  64'd0);
    chk($sformatf("rst%0d.ovf", sel), {63'd0, ovf_v[sel]}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1);
  end

  initial begin
    logic [3:0] eo;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; clr_ovf = 1'b0;
    lv = 4'd0; cmp = 4'd0; lv64 = 64'd0; cmp64 = 64'd0;

    // Wrap mode counting through MAX_VAL from reset.
    for (int i = 1; i <= 12; i++) begin
      eo = (i <= 9) ? 4'(i) : 4'(i - 10);
      tbl.push_back(mk(0, i == 1, 1, 1, 0, 0, 4'd0, 4'd5, eo, i == 10, i >= 10, eo == 4'd5));
    end
    // Saturate mode: repeated down events at 0, clear vs set, up at MAX_VAL.
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 4'd0, 4'd0, 4'd0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 4'd0, 4'd0, 4'd1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 4'd9, 4'd0, 4'd9, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 4'd9, 4'd0, 4'd9, 1, 1, 0));
    // Load clamping, load beats step, down-wrap, sticky ovf.
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 4'd15, 4'd15, 4'd9, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 4'd15, 4'd15, 4'd0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4'd15, 4'd15, 4'd9, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 4'd3,  4'd15, 4'd3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'd3,  4'd15, 4'd3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4'd3,  4'd2,  4'd2, 0, 1, 1));
    // Prescale of 3: en gaps, load restart, mid-prescale direction change, reset.
    tbl.push_back(mk(2, 1, 1, 1, 0, 0, 4'd0, 4'd1, 4'd0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 0, 1, 0, 0, 4'd0, 4'd1, 4'd0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 4'd0, 4'd1, 4'd0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 4'd0, 4'd1, 4'd1, 0, 0, 1));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 4'd0, 4'd1, 4'd1, 0, 0, 1));
    tbl.push_back(mk(2, 0, 1, 1, 1, 0, 4'd5, 4'd1, 4'd5, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 4'd5, 4'd1, 4'd5, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 4'd5, 4'd1, 4'd5, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 4'd5, 4'd1, 4'd6, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 4'd5, 4'd1, 4'd6, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 0, 0, 0, 4'd5, 4'd1, 4'd6, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 0, 0, 0, 4'd5, 4'd1, 4'd5, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 4'd5, 4'd1, 4'd5, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 4'd5, 4'd1, 4'd5, 0, 0, 0));
    tbl.push_back(mk(2, 1, 1, 1, 0, 0, 4'd5, 4'd1, 4'd0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 4'd5, 4'd1, 4'd0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 4'd5, 4'd1, 4'd1, 0, 0, 1));

    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(tbl[i].sel);
      drive(tbl[i].sel, $sformatf("vec%0d", i), tbl[i].en, tbl[i].up, tbl[i].ld,
            tbl[i].clr, tbl[i].lv, tbl[i].cmp, {60'd0, tbl[i].eo},
            tbl[i].etc, tbl[i].eovf, tbl[i].em);
    end

    // Asynchronous reset between edges with out=7, ovf=1.
    do_reset(0);
    drive(0, "async_ld9",  0, 1, 1, 0, 4'd9, 4'd0, 64'd9, 0, 0, 0);
    drive(0, "async_wrap", 1, 1, 0, 0, 4'd9, 4'd0, 64'd0, 1, 1, 1);
    drive(0, "async_ld7",  0, 1, 1, 0, 4'd7, 4'd7, 64'd7, 0, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk("async1.out", get_out(0), 64'd0);
    chk("async1.ovf", {63'd0, ovf_v[0]}, 64'd0);
    chk("async1.tc",  {63'd0, tc_v[0]},  64'd0);
    @(negedge clk);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    drive(0, "async_ld9b",  0, 1, 1, 0, 4'd9, 4'd0, 64'd9, 0, 0, 0);
    drive(0, "async_wrapb", 1, 1, 0, 0, 4'd9, 4'd0, 64'd0, 1, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk("async2.tc",  {63'd0, tc_v[0]},  64'd0);
    chk("async2.ovf", {63'd0, ovf_v[0]}, 64'd0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;

    // Default 64-bit instance wrapping at 2**64-1.
    do_reset(3);
    lv64  = 64'hFFFF_FFFF_FFFF_FFFE;
    cmp64 = 64'd0;
    drive(3, "w64_ld",   0, 1, 1, 0, 4'd0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
    drive(3, "w64_max",  1, 1, 0, 0, 4'd0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    drive(3, "w64_wrap", 1, 1, 0, 0, 4'd0, 4'd0, 64'd0, 1, 1, 1);

    chk("scoreboard.empty", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
